// File: rtl/tri_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_sum_pkg
// Description : Shared lane state encoding, defaults and saturating adder.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_e;

    localparam int c_DEF_LIMIT  = 200;
    localparam int c_DEF_X_INIT = 1;

    // Bit 32 of the result flags saturation; bits [31:0] hold the w-bit sum.
    // Operands are assumed to already fit in w bits.
    function automatic logic [32:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] s;
        logic [31:0] ones;
        s    = {1'b0, a} + {1'b0, b};
        ones = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (s > {1'b0, ones}) begin
            return {1'b1, ones};
        end
        return {1'b0, s[31:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_sum_lane.sv
`default_nettype none
// ============================================================================
// Module      : tri_sum_lane
// Description : One triangular-sum lane: FSM, x/y registers, sticky sat and
//               registered invariant check.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_sum_lane
    import tri_sum_pkg::*;
#(
    parameter int XW     = 15,
    parameter int YW     = 8,
    parameter int LIMIT  = c_DEF_LIMIT,
    parameter int X_INIT = c_DEF_X_INIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic          i_step_en,
    input  logic [YW-1:0] i_limit,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_done,
    output logic          o_sat,
    output logic          o_inv_err,
    output logic          o_run
);

    localparam logic [XW-1:0] c_X_INIT = XW'(X_INIT);
    localparam logic [YW-1:0] c_LIMIT  = YW'(LIMIT);

    lane_state_e   r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_lim;
    logic          r_sat;
    logic          r_inv_err;

    logic [32:0]   w_add;
    logic [YW-1:0] w_y_nxt;
    logic          w_step;

    assign w_add   = sat_add(32'(r_x), 32'(r_y), XW);
    assign w_y_nxt = r_y + YW'(1);
    assign w_step  = (r_state == RUN) && i_step_en && (r_y < r_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_x       <= c_X_INIT;
            r_y       <= '0;
            r_lim     <= c_LIMIT;
            r_sat     <= 1'b0;
            r_inv_err <= 1'b0;
        end else begin
            r_inv_err <= (r_state == DONE) && (32'(r_x) < 32'(r_y));
            if (i_clear) begin
                r_state <= IDLE;
                r_x     <= c_X_INIT;
                r_y     <= '0;
                r_sat   <= 1'b0;
            end else if (i_start) begin
                r_state <= (i_limit == '0) ? DONE : RUN;
                r_x     <= c_X_INIT;
                r_y     <= '0;
                r_sat   <= 1'b0;
                r_lim   <= i_limit;
            end else if (w_step) begin
                r_x <= XW'(w_add[31:0]);
                r_y <= w_y_nxt;
                if (w_add[32]) begin
                    r_sat <= 1'b1;
                end
                // done becomes visible together with y == lim
                if (w_y_nxt == r_lim) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_done    = (r_state == DONE);
    assign o_run     = (r_state == RUN);
    assign o_sat     = r_sat;
    assign o_inv_err = r_inv_err;

endmodule
`default_nettype wire

// File: rtl/tri_sum_engine.sv
`default_nettype none
// ============================================================================
// Module      : tri_sum_engine
// Description : Multi-lane triangular-sum accumulator; packs lane outputs and
//               reduces busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_sum_engine
    import tri_sum_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int XW     = 15,
    parameter int YW     = 8,
    parameter int LIMIT  = c_DEF_LIMIT,
    parameter int X_INIT = c_DEF_X_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [YW-1:0]     limit_in,
    input  logic              clear,
    input  logic [NCH-1:0]    step_en,
    output logic [NCH*XW-1:0] x_out,
    output logic [NCH*YW-1:0] y_out,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    sat,
    output logic [NCH-1:0]    inv_err,
    output logic              busy
);

    logic [NCH-1:0] w_run;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        tri_sum_lane #(
            .XW     (XW),
            .YW     (YW),
            .LIMIT  (LIMIT),
            .X_INIT (X_INIT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_start   (start),
            .i_clear   (clear),
            .i_step_en (step_en[c]),
            .i_limit   (limit_in),
            .o_x       (x_out[c*XW +: XW]),
            .o_y       (y_out[c*YW +: YW]),
            .o_done    (done[c]),
            .o_sat     (sat[c]),
            .o_inv_err (inv_err[c]),
            .o_run     (w_run[c])
        );
    end

    assign busy = |w_run;

endmodule
`default_nettype wire

// File: tb/tb_tri_sum_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_sum_engine
// Description : Self-checking bench for tri_sum_engine (XW=15 and XW=8 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_sum_engine;

    logic        clk = 1'b0;
    logic        rst, start, clear;
    logic [7:0]  limit_in;
    logic [1:0]  step_en;

    logic [29:0] x15;
    logic [15:0] y15, x8, y8;
    logic [1:0]  done15, sat15, inv15, done8, sat8, inv8;
    logic        busy15, busy8;

    int checks = 0;
    int errors = 0;

    // Reference model: [dut][lane]; state 0=idle 1=run 2=done
    int mst[2][2], mx[2][2], my[2][2], mlim[2][2], msat[2][2], minv[2][2];
    int xmax[2] = '{32767, 255};

    always #5 clk = ~clk;

    tri_sum_engine dut (
        .clk(clk), .rst(rst), .start(start), .limit_in(limit_in), .clear(clear),
        .step_en(step_en), .x_out(x15), .y_out(y15), .done(done15), .sat(sat15),
        .inv_err(inv15), .busy(busy15)
    );

    tri_sum_engine #(.XW(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .limit_in(limit_in), .clear(clear),
        .step_en(step_en), .x_out(x8), .y_out(y8), .done(done8), .sat(sat8),
        .inv_err(inv8), .busy(busy8)
    );

    function automatic logic [31:0] gx(int d, int c);
        if (d == 0) return 32'(x15[c*15 +: 15]);
        return 32'(x8[c*8 +: 8]);
    endfunction

    function automatic logic [31:0] gy(int d, int c);
        if (d == 0) return 32'(y15[c*8 +: 8]);
        return 32'(y8[c*8 +: 8]);
    endfunction

    task automatic chk(string nm, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_edge(bit r, bit st, int lv, bit cl, bit [1:0] en);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                int inv_n;
                inv_n = (mst[d][c] == 2 && mx[d][c] < my[d][c]) ? 1 : 0;
                if (r) begin
                    mst[d][c] = 1; mx[d][c] = 1; my[d][c] = 0;
                    mlim[d][c] = 200; msat[d][c] = 0; minv[d][c] = 0;
                end else begin
                    minv[d][c] = inv_n;
                    if (cl) begin
                        mst[d][c] = 0; mx[d][c] = 1; my[d][c] = 0; msat[d][c] = 0;
                    end else if (st) begin
                        mx[d][c] = 1; my[d][c] = 0; msat[d][c] = 0;
                        mlim[d][c] = lv;
                        mst[d][c] = (lv == 0) ? 2 : 1;
                    end else if (mst[d][c] == 1 && en[c] && my[d][c] < mlim[d][c]) begin
                        int s;
                        s = mx[d][c] + my[d][c];
                        if (s > xmax[d]) begin
                            s = xmax[d];
                            msat[d][c] = 1;
                        end
                        mx[d][c] = s;
                        my[d][c]++;
                        if (my[d][c] == mlim[d][c]) mst[d][c] = 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int anyrun;
            anyrun = 0;
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("d%0d_l%0d_x", d, c), gx(d, c), mx[d][c]);
                chk($sformatf("d%0d_l%0d_y", d, c), gy(d, c), my[d][c]);
                chk($sformatf("d%0d_l%0d_done", d, c),
                    32'(d == 0 ? done15[c] : done8[c]), (mst[d][c] == 2) ? 1 : 0);
                chk($sformatf("d%0d_l%0d_sat", d, c),
                    32'(d == 0 ? sat15[c] : sat8[c]), msat[d][c]);
                chk($sformatf("d%0d_l%0d_inv", d, c),
                    32'(d == 0 ? inv15[c] : inv8[c]), minv[d][c]);
                if (mst[d][c] == 1) anyrun = 1;
            end
            chk($sformatf("d%0d_busy", d), 32'(d == 0 ? busy15 : busy8), anyrun);
        end
    endtask

    task automatic cycle(bit r, bit st, int lv, bit cl, bit [1:0] en);
        rst = r; start = st; limit_in = 8'(lv); clear = cl; step_en = en;
        @(posedge clk);
        #1;
        model_edge(r, st, lv, cl, en);
        compare_all();
    endtask

    typedef struct {
        bit       st;
        int       lv;
        bit       cl;
        bit [1:0] en;
        int       x0, y0, x1, y1;
        bit [1:0] dn;
        bit       bz;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // limit 5 on lane 0 only
        tbl[0]  = '{1, 5, 0, 2'b00, 1, 0, 1, 0, 2'b00, 1};
        tbl[1]  = '{0, 0, 0, 2'b01, 1, 1, 1, 0, 2'b00, 1};
        tbl[2]  = '{0, 0, 0, 2'b01, 2, 2, 1, 0, 2'b00, 1};
        tbl[3]  = '{0, 0, 0, 2'b01, 4, 3, 1, 0, 2'b00, 1};
        tbl[4]  = '{0, 0, 0, 2'b01, 7, 4, 1, 0, 2'b00, 1};
        tbl[5]  = '{0, 0, 0, 2'b01, 11, 5, 1, 0, 2'b01, 1};
        tbl[6]  = '{0, 0, 0, 2'b01, 11, 5, 1, 0, 2'b01, 1};
        // limit 0: immediately done, steps ignored
        tbl[7]  = '{1, 0, 0, 2'b11, 1, 0, 1, 0, 2'b11, 0};
        tbl[8]  = '{0, 0, 0, 2'b11, 1, 0, 1, 0, 2'b11, 0};
        // clear beats start mid-run
        tbl[9]  = '{1, 20, 0, 2'b00, 1, 0, 1, 0, 2'b00, 1};
        tbl[10] = '{0, 0, 0, 2'b11, 1, 1, 1, 1, 2'b00, 1};
        tbl[11] = '{0, 0, 0, 2'b11, 2, 2, 2, 2, 2'b00, 1};
        tbl[12] = '{0, 0, 0, 2'b11, 4, 3, 4, 3, 2'b00, 1};
        tbl[13] = '{1, 20, 1, 2'b11, 1, 0, 1, 0, 2'b00, 0};
        tbl[14] = '{0, 0, 0, 2'b11, 1, 0, 1, 0, 2'b00, 0};
        // start beats step mid-run
        tbl[15] = '{1, 10, 0, 2'b00, 1, 0, 1, 0, 2'b00, 1};
        tbl[16] = '{0, 0, 0, 2'b11, 1, 1, 1, 1, 2'b00, 1};
        tbl[17] = '{0, 0, 0, 2'b11, 2, 2, 2, 2, 2'b00, 1};
        tbl[18] = '{1, 10, 0, 2'b11, 1, 0, 1, 0, 2'b00, 1};

        // Reset state
        cycle(1, 0, 0, 0, 2'b00);
        cycle(1, 0, 0, 0, 2'b11);
        chk("rst_x0", gx(0, 0), 1);
        chk("rst_y1", gy(0, 1), 0);
        chk("rst_done", 32'(done15), 0);
        chk("rst_busy", 32'(busy15), 1);

        // Count straight out of reset to the default limit
        for (int k = 1; k <= 250; k++) begin
            cycle(0, 0, 0, 0, 2'b11);
            if (k == 199) chk("def_done_early", 32'(done15), 0);
            if (k == 200) begin
                chk("def_y_at_done", gy(0, 0), 200);
                chk("def_done_rise", 32'(done15), 3);
            end
        end
        chk("def_x0", gx(0, 0), 19901);
        chk("def_x1", gx(0, 1), 19901);
        chk("def_y1", gy(0, 1), 200);
        chk("def_busy", 32'(busy15), 0);
        chk("def_sat", 32'(sat15), 0);
        chk("def_inv", 32'(inv15), 0);

        for (int i = 0; i < 19; i++) begin
            cycle(0, tbl[i].st, tbl[i].lv, tbl[i].cl, tbl[i].en);
            chk($sformatf("tbl%0d_x0", i), gx(0, 0), tbl[i].x0);
            chk($sformatf("tbl%0d_y0", i), gy(0, 0), tbl[i].y0);
            chk($sformatf("tbl%0d_x1", i), gx(0, 1), tbl[i].x1);
            chk($sformatf("tbl%0d_y1", i), gy(0, 1), tbl[i].y1);
            chk($sformatf("tbl%0d_done", i), 32'(done15), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_busy", i), 32'(busy15), 32'(tbl[i].bz));
        end
        for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0, 2'b11);
        chk("restart_y", gy(0, 0), 10);
        chk("restart_x", gx(0, 0), 46);
        chk("restart_done", 32'(done15), 3);

        // Saturation on the 8-bit copy
        cycle(0, 1, 30, 0, 2'b00);
        for (int k = 1; k <= 32; k++) begin
            cycle(0, 0, 0, 0, 2'b11);
            if (k == 23) begin
                chk("sat8_x23", gx(1, 0), 254);
                chk("sat8_s23", 32'(sat8[0]), 0);
            end
            if (k == 24) begin
                chk("sat8_x24", gx(1, 0), 255);
                chk("sat8_s24", 32'(sat8[0]), 1);
            end
        end
        chk("sat8_xf", gx(1, 0), 255);
        chk("sat8_yf", gy(1, 0), 30);
        chk("sat8_done", 32'(done8), 3);
        chk("sat8_inv", 32'(inv8), 0);
        chk("sat15_x", gx(0, 0), 436);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            bit r, st, cl;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 39) == 0);
            cycle(r, st, int'($urandom_range(0, 40)), cl, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tri_sum_engine.md
Name: tri_sum_engine

Overview:
- Multi-lane triangular-sum accumulator and the parametrised successor of the single x/y step accumulator used in the property-mining arithmetic cases.
- Each lane runs x <= x + y, y <= y + 1 on its own step enable, until y reaches a run-time limit.
- Adds start/clear control, per-lane DONE state, saturating x arithmetic, and a built-in invariant monitor (x >= y at DONE) for formal and simulation checking.

Parameters:
- NCH, 2, number of independent lanes
- XW, 15, width of each x accumulator
- YW, 8, width of each y counter and of the limit
- LIMIT, 200, limit used after reset until the first start
- X_INIT, 1, value loaded into x on reset, start or clear; must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; re-arms all lanes and latches limit_in
- limit_in  in  YW  step limit sampled on start
- clear  in  1  pulse; returns all lanes to IDLE with init values
- step_en  in  NCH  per-lane step request (selector)
- x_out  out  NCH*XW  lane c occupies bits [c*XW +: XW]
- y_out  out  NCH*YW  lane c occupies bits [c*YW +: YW]
- done  out  NCH  lane in DONE state
- sat  out  NCH  sticky: lane x has saturated
- inv_err  out  NCH  lane in DONE with x < y (must never assert)
- busy  out  1  OR of the RUN state over all lanes

Behaviour:
- Reset:
  - every lane enters RUN with x=X_INIT, y=0, lim=LIMIT, sat=0.
  - done=0, inv_err=0, busy=1 from the first cycle after reset.
  - This matches the legacy behaviour, which counts straight out of reset.
- Per-lane states: IDLE, RUN, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE: x and y hold; step_en is ignored.
- RUN:
  - If step_en[c]=1 and y < lim: x <= sat_add(x, y), y <= y + 1, all on the same edge.
  - If y + 1 == lim on that step, the state moves to DONE on the same edge, so done rises in the cycle y_out==lim is first visible.
  - If step_en[c]=0: x and y hold.
- DONE: x and y hold; step_en is ignored.
- Saturation:
  - sat_add computes x + zero-extended y in XW+1 bits.
  - If the carry is set, x <= all ones and sat[c] <= 1.
  - sat is sticky until start, clear or rst.
  - y never wraps, because a step is only taken while y < lim.
- start (all lanes):
  - x=X_INIT, y=0, sat=0, lim=limit_in.
  - State becomes RUN, or DONE if limit_in==0.
  - start is honoured in any state, including mid-RUN (restart).
- clear (all lanes): x=X_INIT, y=0, sat=0, state IDLE; lim is unchanged.
- Priority: rst > clear > start > step.
  - clear and start in the same cycle means clear wins.
  - start and step_en in the same cycle means start wins and no step is taken.
- inv_err[c] is registered; next cycle it equals (state==DONE && x < y).
- Latency: one cycle from step_en to the updated x_out/y_out.

Decomposition:
- Package tri_sum_pkg holds:
  - lane_state_e enum {IDLE, RUN, DONE}
  - function sat_add (parametrised by width through the caller)
  - localparam defaults for LIMIT and X_INIT
- Sub-module tri_sum_lane holds one lane's FSM, x/y registers, sat and inv_err, and is instantiated NCH times by a generate loop.
- The top level does the output packing and the busy OR-reduction.

Test Plan:
- Defaults, release rst, hold step_en=2'b11 for 250 cycles -> y_out stops at 200 and x_out at 19901 per lane; done=2'b11 in the cycle y=200 appears; busy=0; sat=0; inv_err=0.
- start with limit_in=5, step_en[0]=1 continuously -> lane 0 x sequence 1,1,2,4,7,11 with y 0..5; done[0] rises with y=5; lane 1 stays x=1, y=0 in RUN while its step_en is 0.
- XW=8, start with limit_in=30, steps continuous -> after step 23 x=254; step 24 clamps x=255 and sets sat=1; final x=255, y=30, done=1, inv_err=0.
- start with limit_in=0 -> next cycle done=all ones, x=1, y=0; step_en is ignored.
- Mid-RUN (y=3) assert clear and start together -> lanes enter IDLE with x=1, y=0, done=0; steps are ignored until the next start.
- Mid-RUN start with limit_in=10 while step_en=1 -> no step on the start cycle; counting restarts from x=1, y=0 and reaches y=10, x=46.
